// File: rtl/sr_latch_driver_if.sv
// sr_latch_driver_if: command handshake, latch drive and latch feedback bundle
interface sr_latch_driver_if;
  logic cmd_valid;
  logic cmd_set;
  logic cmd_ready;
  logic S_bar;
  logic R_bar;
  logic q_in;
  logic q_bar_in;
  logic done;
  logic sts_q;
  logic err;
  logic err_clr;
  logic busy;
  modport master (
    output cmd_valid, cmd_set, q_in, q_bar_in, err_clr,
    input  cmd_ready, S_bar, R_bar, done, sts_q, err, busy
  );
  modport slave (
    input  cmd_valid, cmd_set, q_in, q_bar_in, err_clr,
    output cmd_ready, S_bar, R_bar, done, sts_q, err, busy
  );
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns set/reset commands into exclusive active-low latch pulses and verifies the result
module sr_latch_driver #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  sr_latch_driver_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, PULSE, CHECK, GAP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic cmd_reg, cmd_n, match;
  // latch must sit at the commanded value with complementary outputs
  assign match = (bus.q_in == cmd_reg) && (bus.q_bar_in != bus.q_in);
  assign bus.cmd_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  // next state, counter and command capture
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cmd_n = cmd_reg;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        state_n = PULSE;
        cnt_n = CNT_W'(PULSE_W - 1);
        cmd_n = bus.cmd_set;
      end
      PULSE: begin
        state_n = cnt == '0 ? CHECK : PULSE;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
      end
      CHECK: begin
        state_n = GAP;
        cnt_n = CNT_W'(GAP_W - 1);
      end
      default: begin
        state_n = cnt == '0 ? IDLE : GAP;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
      end
    endcase
  end
  // bars are decoded from the next state so at most one can ever be low
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd_reg <= 1'b0;
      bus.S_bar <= 1'b1;
      bus.R_bar <= 1'b1;
      bus.done <= 1'b0;
      bus.sts_q <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cmd_reg <= cmd_n;
      bus.S_bar <= !(state_n == PULSE && cmd_n);
      bus.R_bar <= !(state_n == PULSE && !cmd_n);
      bus.done <= state == CHECK;
      bus.sts_q <= state == CHECK ? bus.q_in : bus.sts_q;
      bus.err <= (state == CHECK && !match) || (bus.err && !bus.err_clr);
    end
  end
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed checks of the latch driver against a behavioral NAND latch
module tb_sr_latch_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fault = 1'b0;
  logic lq = 1'b0;
  logic lqb = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;
  int forbidden = 0;
  int done_cnt = 0;
  int cyc = 0;
  sr_latch_driver_if bus();
  sr_latch_driver dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // behavioral NAND SR latch with a fault override on its feedback
  always @(bus.S_bar or bus.R_bar) begin
    if (!bus.S_bar && !bus.R_bar) {lq, lqb} = 2'b11;
    else if (!bus.S_bar) {lq, lqb} = 2'b10;
    else if (!bus.R_bar) {lq, lqb} = 2'b01;
  end
  assign bus.q_in = fault ? 1'b0 : lq;
  assign bus.q_bar_in = fault ? 1'b1 : lqb;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.S_bar === 1'b0 && bus.R_bar === 1'b0) forbidden <= forbidden + 1;
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int prev, waitc, d0;
    bus.cmd_valid = 0; bus.cmd_set = 0; bus.err_clr = 0;
    nc(2);
    rst = 0;
    nc(1);
    chk("rst_s_bar", bus.S_bar, 1); chk("rst_r_bar", bus.R_bar, 1);
    chk("rst_ready", bus.cmd_ready, 1); chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0); chk("rst_err", bus.err, 0);
    bus.cmd_valid = 1; bus.cmd_set = 1;
    nc(1);
    bus.cmd_valid = 0;
    chk("set_s1", bus.S_bar, 0); chk("set_r1", bus.R_bar, 1);
    chk("set_busy", bus.busy, 1); chk("set_ready", bus.cmd_ready, 0);
    nc(1);
    chk("set_s2", bus.S_bar, 0); chk("set_r2", bus.R_bar, 1);
    nc(1);
    chk("set_chk_s", bus.S_bar, 1); chk("set_chk_done", bus.done, 0);
    nc(1);
    chk("set_done", bus.done, 1); chk("set_sts", bus.sts_q, 1); chk("set_err", bus.err, 0);
    nc(1);
    chk("set_ready_back", bus.cmd_ready, 1); chk("set_done_low", bus.done, 0);
    bus.cmd_valid = 1; bus.cmd_set = 0;
    nc(1);
    bus.cmd_valid = 0;
    chk("rs_r1", bus.R_bar, 0); chk("rs_s1", bus.S_bar, 1);
    nc(1);
    chk("rs_r2", bus.R_bar, 0);
    nc(2);
    chk("rs_done", bus.done, 1); chk("rs_sts", bus.sts_q, 0); chk("rs_latch_q", lq, 0);
    nc(1);
    bus.cmd_valid = 1;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      bus.cmd_set = ~i[0];
      waitc = 0;
      while (!bus.cmd_ready && waitc < 20) begin nc(1); waitc++; end
      chk("b2b_ready_seen", bus.cmd_ready, 1);
      if (i > 0) chk("b2b_spacing", cyc - prev, 5);
      prev = cyc;
      nc(1);
    end
    bus.cmd_valid = 0;
    nc(5);
    chk("b2b_err", bus.err, 0); chk("b2b_latch_q", lq, 0); chk("b2b_sts", bus.sts_q, 0);
    fault = 1;
    bus.cmd_valid = 1; bus.cmd_set = 1;
    nc(1);
    bus.cmd_valid = 0;
    nc(2);
    chk("flt_err_pre", bus.err, 0);
    nc(1);
    chk("flt_done", bus.done, 1); chk("flt_err", bus.err, 1); chk("flt_sts", bus.sts_q, 0);
    nc(1);
    fault = 0;
    bus.cmd_valid = 1; bus.cmd_set = 1;
    nc(1);
    bus.cmd_valid = 0;
    nc(3);
    chk("pass_done", bus.done, 1); chk("pass_sts", bus.sts_q, 1); chk("sticky_err", bus.err, 1);
    nc(1);
    fault = 1;
    bus.cmd_valid = 1; bus.cmd_set = 1;
    nc(1);
    bus.cmd_valid = 0;
    nc(2);
    bus.err_clr = 1;
    nc(1);
    bus.err_clr = 0;
    chk("clr_vs_mismatch", bus.err, 1);
    nc(1);
    fault = 0;
    bus.err_clr = 1;
    nc(1);
    bus.err_clr = 0;
    chk("quiet_clr", bus.err, 0);
    bus.cmd_valid = 1; bus.cmd_set = 1;
    nc(1);
    chk("mid_s_low", bus.S_bar, 0);
    rst = 1;
    nc(1);
    rst = 0; bus.cmd_valid = 0;
    chk("mid_s_bar", bus.S_bar, 1); chk("mid_busy", bus.busy, 0); chk("mid_ready", bus.cmd_ready, 1);
    d0 = done_cnt;
    nc(10);
    chk("mid_no_done", done_cnt - d0, 0); chk("mid_no_err", bus.err, 0);
    bus.cmd_valid = 1; bus.cmd_set = 0;
    nc(1);
    bus.cmd_valid = 0;
    chk("post_r_low", bus.R_bar, 0); chk("post_busy", bus.busy, 1);
    nc(3);
    chk("post_done", bus.done, 1); chk("post_sts", bus.sts_q, 0); chk("post_err", bus.err, 0);
    chk("never_forbidden", forbidden, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
